// File: rtl/quant_sched.sv
// quant_sched: walks a frame of 18-bit accumulator beats through the external
// Quant pipeline. It presents each channel's scale/shift/zero-point at the stage
// that consumes it, and uses credits plus an output FIFO to give Quant a
// ready/valid interface.
module quant_sched #(
    parameter int unsigned CH_NUM     = 16,
    parameter int unsigned CH_W       = 4,
    parameter int unsigned QLAT       = 3,
    parameter int unsigned SCL_DLY    = 1,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            cfg_we,
    input  logic [CH_W-1:0] cfg_ch,
    input  logic [15:0]     cfg_scale,
    input  logic [3:0]      cfg_shift,
    input  logic [7:0]      cfg_zp,
    input  logic            start,
    input  logic [15:0]     frame_len,
    output logic            busy,
    output logic            done,
    input  logic            in_valid,
    input  logic [17:0]     in_data,
    output logic            in_ready,
    output logic [17:0]     q_acc,
    output logic [15:0]     q_scale,
    output logic [3:0]      q_shift,
    output logic [7:0]      q_zp,
    input  logic [7:0]      q_result,
    output logic            out_valid,
    output logic [7:0]      out_data,
    output logic [CH_W-1:0] out_ch,
    input  logic            out_ready
);

    localparam int unsigned CNT_W = 16;
    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned FC_W  = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned IF_W  = $clog2(QLAT + 2);
    localparam int unsigned OCC_W = FC_W + IF_W;
    localparam int unsigned ENT_W = 8 + CH_W;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

    state_t             state;
    logic [CNT_W-1:0]   in_cnt;
    logic [CH_W-1:0]    ch;

    logic [15:0]        tbl_scale [CH_NUM];
    logic [3:0]         tbl_shift [CH_NUM];
    logic [7:0]         tbl_zp    [CH_NUM];

    logic               acc_vld;
    logic [CH_W-1:0]    acc_ch;
    logic [15:0]        acc_scale;
    logic [3:0]         acc_shift;
    logic [7:0]         acc_zp;

    logic [15:0]        scl_sr [SCL_DLY];
    logic [3:0]         shf_sr [SCL_DLY];
    logic [7:0]         zp_sr  [QLAT];
    logic               vld_sr [QLAT];
    logic [CH_W-1:0]    ch_sr  [QLAT];

    logic [IF_W-1:0]    inflight;
    logic [ENT_W-1:0]   fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [FC_W-1:0]    fifo_count;

    logic               accept;
    logic               push;
    logic               pop;
    logic               fifo_full;
    logic [OCC_W-1:0]   occ;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(FIFO_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    // Credit check: beats still inside Quant count as FIFO occupancy.
    assign occ       = OCC_W'(fifo_count) + OCC_W'(inflight);
    assign in_ready  = (state == S_RUN) && (in_cnt != '0) && (occ < OCC_W'(FIFO_DEPTH));
    assign accept    = in_valid && in_ready;
    assign push      = vld_sr[QLAT-1];
    assign pop       = out_valid && out_ready;
    assign fifo_full = (fifo_count == FC_W'(FIFO_DEPTH));

    assign q_scale   = scl_sr[SCL_DLY-1];
    assign q_shift   = shf_sr[SCL_DLY-1];
    assign q_zp      = zp_sr[QLAT-1];
    assign out_valid = (fifo_count != '0);
    assign out_data  = fifo_mem[rd_ptr][ENT_W-1:CH_W];
    assign out_ch    = fifo_mem[rd_ptr][CH_W-1:0];

    // Parameter table; writable in any state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < CH_NUM; i++) begin
                tbl_scale[i] <= '0;
                tbl_shift[i] <= '0;
                tbl_zp[i]    <= '0;
            end
        end else if (cfg_we) begin
            tbl_scale[cfg_ch] <= cfg_scale;
            tbl_shift[cfg_ch] <= cfg_shift;
            tbl_zp[cfg_ch]    <= cfg_zp;
        end
    end

    // Frame control FSM with registered busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            in_cnt <= '0;
            ch     <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        if (frame_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state  <= S_RUN;
                            busy   <= 1'b1;
                            in_cnt <= frame_len;
                            ch     <= '0;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        in_cnt <= in_cnt - CNT_W'(1);
                        ch     <= (ch == CH_W'(CH_NUM - 1)) ? '0 : ch + CH_W'(1);
                        if (in_cnt == CNT_W'(1)) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (fifo_count == '0 && inflight == '0) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Issue stage: beat and its channel parameters captured together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_acc     <= '0;
            acc_vld   <= 1'b0;
            acc_ch    <= '0;
            acc_scale <= '0;
            acc_shift <= '0;
            acc_zp    <= '0;
        end else begin
            acc_vld <= accept;
            if (accept) begin
                q_acc     <= in_data;
                acc_ch    <= ch;
                acc_scale <= tbl_scale[ch];
                acc_shift <= tbl_shift[ch];
                acc_zp    <= tbl_zp[ch];
            end else begin
                q_acc     <= '0;
                acc_ch    <= '0;
                acc_scale <= '0;
                acc_shift <= '0;
                acc_zp    <= '0;
            end
        end
    end

    // Delay lines aligning parameters and beat tags with Quant's stages.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < SCL_DLY; i++) begin
                scl_sr[i] <= '0;
                shf_sr[i] <= '0;
            end
            for (int unsigned i = 0; i < QLAT; i++) begin
                zp_sr[i]  <= '0;
                vld_sr[i] <= 1'b0;
                ch_sr[i]  <= '0;
            end
            inflight <= '0;
        end else begin
            scl_sr[0] <= acc_scale;
            shf_sr[0] <= acc_shift;
            for (int unsigned i = 1; i < SCL_DLY; i++) begin
                scl_sr[i] <= scl_sr[i-1];
                shf_sr[i] <= shf_sr[i-1];
            end
            zp_sr[0]  <= acc_zp;
            vld_sr[0] <= acc_vld;
            ch_sr[0]  <= acc_ch;
            for (int unsigned i = 1; i < QLAT; i++) begin
                zp_sr[i]  <= zp_sr[i-1];
                vld_sr[i] <= vld_sr[i-1];
                ch_sr[i]  <= ch_sr[i-1];
            end
            inflight <= inflight + IF_W'(accept) - IF_W'(push);
        end
    end

    // Output FIFO capturing Quant results tagged with their channel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) fifo_mem[i] <= '0;
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
        end else begin
            if (push) begin
                fifo_mem[wr_ptr] <= {q_result, ch_sr[QLAT-1]};
                wr_ptr           <= ptr_inc(wr_ptr);
            end
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            case ({push, pop})
                2'b10:   fifo_count <= fifo_count + FC_W'(1);
                2'b01:   fifo_count <= fifo_count - FC_W'(1);
                default: fifo_count <= fifo_count;
            endcase
        end
    end

    // Credits must make a push into a full FIFO impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && fifo_full));

endmodule
